mult_div_unit: RTL and testbench
================================

# mult_div_unit

Parametrised multicycle multiply/divide unit for the MIPS datapath. It takes operands from the A/B registers and computes signed or unsigned products and quotient/remainder pairs, one bit per cycle. Results are held in internal HI/LO registers that feed the register-file write-data mux. It is the successor of the fixed 32-bit mult/div blocks: it adds a width parameter, an unsigned mode, start/busy/done handshaking and divide-by-zero reporting.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mult_start`  in  1  one-cycle pulse that starts a multiply (driven by `multControl`).
- `div_start`  in  1  one-cycle pulse that starts a divide (driven by `divControl`).
- `unsigned_op`  in  1  0 = signed (mult/div), 1 = unsigned (multu/divu); sampled with the start pulse.
- `op_a`  in  WIDTH  multiplicand or dividend; sampled with the start pulse.
- `op_b`  in  WIDTH  multiplier or divisor; sampled with the start pulse.
- `busy`  out  1  high from the cycle after an accepted start until `done`, inclusive.
- `done`  out  1  one-cycle pulse; HI/LO are valid from this cycle on.
- `div_by_zero`  out  1  registered flag; set with `done` when a divide had `op_b == 0`.
- `hi`  out  WIDTH  product upper half, or remainder.
- `lo`  out  WIDTH  product lower half, or quotient.

## Operation
- FSM states: IDLE, MULT, DIV, FINISH.
- Start acceptance:
  - A start is accepted only in IDLE.
  - Starts in any other state are ignored (no queueing).
  - If `mult_start` and `div_start` are high together, the multiply wins.
- Accepted start:
  - Latch the operands and the mode.
  - Convert operands to magnitudes when signed.
  - Record the result signs.
  - Load the counter with `WIDTH`.
  - Go to MULT or DIV.
- MULT: shift-add, one multiplier bit per cycle. The counter decrements; when it reaches 0, go to FINISH.
- DIV: restoring division, one quotient bit per cycle into a `WIDTH+1`-bit partial remainder. The counter decrements; when it reaches 0, go to FINISH.
- Divide by zero (`op_b == 0` at start):
  - Skip DIV and go directly to FINISH.
  - `div_by_zero` is 1, and `hi`/`lo` are NOT written.
- FINISH:
  - Apply the sign correction to the result.
  - Write `hi`/`lo`.
  - Pulse `done` and return to IDLE.
- Signed result rules:
  - Product is the two's-complement 2·WIDTH result.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Most-negative / −1 gives `lo` = most-negative and `hi` = 0, with no flag.
- `div_by_zero` updates only in FINISH: it is cleared by any successful completion and holds its value otherwise.
- `hi`/`lo` hold their last values until the next successful completion.

## Timing
- Reset values: all outputs 0; state IDLE; counter 0.
- Reset is asynchronous and may assert mid-operation. The operation is abandoned, no `done` is produced, and `hi`/`lo` are cleared to 0.
- Start sampled at edge 0:
  - `busy` is high in cycles 1..WIDTH+1.
  - `done` is high in cycle WIDTH+1, and `hi`/`lo` are updated at that same edge.
  - Latency is WIDTH+1 cycles.
- Divide by zero: `busy` and `done` are both high in cycle 1 only.
- The earliest back-to-back start is the `done` cycle + 1, i.e. the next IDLE cycle.
- Outputs are registered, with no combinational path from inputs to outputs.

## Structure
- `mult_div_pkg` holds:
  - the state enum (IDLE/MULT/DIV/FINISH);
  - the counter-width function `$clog2(WIDTH+1)`;
  - the reset constants.
- Sub-module `div_step`: combinational single restoring step. Inputs: partial remainder, divisor, next dividend bit. Outputs: new remainder and quotient bit. It is instantiated once and iterated by the FSM.

## Test plan
- Signed multiply, WIDTH=32, 7 × −3 → `done` at cycle 33, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, `busy` high for 33 cycles.
- Unsigned multiply, 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- Signed divide:
  - −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - 0x80000000 / −1 → `lo`=0x80000000, `hi`=0, `div_by_zero`=0.
- Divide by zero after a prior result (`hi`=5, `lo`=9): 10 / 0 → `done` and `div_by_zero` in cycle 1, `hi`/`lo` stay 5/9. The next valid divide clears the flag.
- Starts while busy are ignored; simultaneous `mult_start` and `div_start` runs a multiply. Then drop `reset` low at cycle 10 of a multiply → all outputs 0 at once, no `done`. A fresh start after release completes normally.
- WIDTH=8 instance, unsigned 200 / 7 → `done` at cycle 9, `lo`=28, `hi`=4.

Source files
------------

// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared state type, counter sizing and reset
// constants for the multicycle multiply/divide unit.
package mult_div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MULT   = 2'd1,
        DIV    = 2'd2,
        FINISH = 2'd3
    } state_e;

    localparam state_e RST_STATE = IDLE;
    localparam logic   RST_FLAG  = 1'b0;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_div_if.sv
// mult_div_if: start/operand/result bundle between the
// datapath control and the multiply/divide unit.
interface mult_div_if #(
    parameter int WIDTH = 32
);

    logic             mult_start;
    logic             div_start;
    logic             unsigned_op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output mult_start, div_start, unsigned_op, op_a, op_b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  mult_start, div_start, unsigned_op, op_a, op_b,
        output busy, done, div_by_zero, hi, lo
    );

endinterface

// File: rtl/mult_div_unit_div_step.sv
// div_step: one restoring-division step, shift in the next
// dividend bit and subtract the divisor if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] dvsr_i,
    input  logic             bit_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // remainder stays below the divisor, so the top bit of
    // diff is a clean borrow flag
    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {2'b00, dvsr_i};
    assign q_o     = ~diff[WIDTH+1];
    assign rem_o   = q_o ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed/unsigned multiply and divide,
// one bit per cycle, results held in HI/LO.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    mult_div_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);

    state_e state_q, state_d;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic               start;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     step_rem;
    logic               step_q;
    logic [WIDTH-1:0]   quo;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      cnt_dec;

    assign start = (state_q == IDLE)
                && (bus.mult_start || bus.div_start);
    assign a_neg = !bus.unsigned_op && bus.op_a[WIDTH-1];
    assign b_neg = !bus.unsigned_op && bus.op_b[WIDTH-1];
    assign a_mag = a_neg ? -bus.op_a : bus.op_a;
    assign b_mag = b_neg ? -bus.op_b : bus.op_b;

    // shift-add: acc holds the running upper half, sh the
    // multiplier being consumed from the bottom
    assign sum  = {1'b0, acc_q[WIDTH-1:0]}
                + (sh_q[0] ? {1'b0, a_q} : '0);
    assign prod = {sum, sh_q[WIDTH-1:1]};
    assign quo  = {sh_q[WIDTH-2:0], step_q};

    assign cnt_dec = cnt_q - CW'(1);

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_i  (acc_q),
        .dvsr_i (b_q),
        .bit_i  (sh_q[WIDTH-1]),
        .rem_o  (step_rem),
        .q_o    (step_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.mult_start) begin
                    state_d = MULT;
                end else if (bus.div_start) begin
                    state_d = (bus.op_b == '0) ? FINISH : DIV;
                end
            end
            MULT, DIV: begin
                if (cnt_dec == '0) state_d = FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = RST_STATE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        sh_d      = sh_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == FINISH);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d     = CW'(WIDTH);
                    acc_d     = '0;
                    a_d       = a_mag;
                    b_d       = b_mag;
                    sh_d      = bus.mult_start ? b_mag : a_mag;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    if (state_d == FINISH) dbz_d = 1'b1;
                end
            end
            MULT: begin
                cnt_d = cnt_dec;
                acc_d = {1'b0, sum[WIDTH:1]};
                sh_d  = {sum[0], sh_q[WIDTH-1:1]};
                if (state_d == FINISH) begin
                    {hi_d, lo_d} = neg_res_q ? -prod : prod;
                    dbz_d        = 1'b0;
                end
            end
            DIV: begin
                cnt_d = cnt_dec;
                acc_d = step_rem;
                sh_d  = quo;
                if (state_d == FINISH) begin
                    lo_d  = neg_res_q ? -quo : quo;
                    hi_d  = neg_rem_q ? -step_rem[WIDTH-1:0]
                                      : step_rem[WIDTH-1:0];
                    dbz_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sh_q      <= '0;
            acc_q     <= '0;
            neg_res_q <= RST_FLAG;
            neg_rem_q <= RST_FLAG;
            busy_q    <= RST_FLAG;
            done_q    <= RST_FLAG;
            dbz_q     <= RST_FLAG;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sh_q      <= sh_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for 32- and 8-bit
// instances against an arithmetic reference model.
module tb_mult_div_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        bit          dbz;
        bit          wr;
        int          e;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult_div_if #(.WIDTH(32)) b32 ();
    mult_div_if #(.WIDTH(8))  b8 ();

    mult_div_unit #(.WIDTH(32)) u32 (
        .clk   (clk),
        .reset (reset),
        .bus   (b32.slave)
    );

    mult_div_unit #(.WIDTH(8)) u8 (
        .clk   (clk),
        .reset (reset),
        .bus   (b8.slave)
    );

    exp_t        q0[$];
    exp_t        q1[$];
    int          free_e[2];
    logic [31:0] hh[2];
    logic [31:0] hl[2];
    bit          hd[2];
    int          nvec = 0;
    int          nbad = 0;

    function automatic void chk(input string nm,
                                input logic [31:0] act,
                                input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nbad++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     nm, act, req, cyc);
        end
    endfunction

    // reference: plain integer arithmetic on sign-extended operands
    function automatic exp_t model(input int w, input bit m,
                                   input bit u,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t        e;
        longint      mask, top, sa, sb, q, r;
        logic [63:0] p;
        mask = (longint'(1) << w) - 1;
        top  = longint'(1) << (w - 1);
        sa   = longint'(a) & mask;
        sb   = longint'(b) & mask;
        if (!u) begin
            sa = (sa ^ top) - top;
            sb = (sb ^ top) - top;
        end
        e     = '{hi: 0, lo: 0, dbz: 0, wr: 1, e: 0, lat: w + 1};
        if (m) begin
            p    = sa * sb;
            e.hi = 32'((p >> w) & mask);
            e.lo = 32'(p & mask);
        end else if (sb == 0) begin
            e.dbz = 1;
            e.wr  = 0;
            e.lat = 1;
        end else begin
            q    = sa / sb;
            r    = sa % sb;
            e.hi = 32'(r & mask);
            e.lo = 32'(q & mask);
        end
        return e;
    endfunction

    task automatic drive(input int id, input bit m, input bit d,
                         input bit u, input logic [31:0] a,
                         input logic [31:0] b);
        if (id == 0) begin
            b32.mult_start  = m;
            b32.div_start   = d;
            b32.unsigned_op = u;
            b32.op_a        = a;
            b32.op_b        = b;
        end else begin
            b8.mult_start  = m;
            b8.div_start   = d;
            b8.unsigned_op = u;
            b8.op_a        = a[7:0];
            b8.op_b        = b[7:0];
        end
    endtask

    task automatic issue(input int id, input bit m, input bit d,
                         input bit u, input logic [31:0] a,
                         input logic [31:0] b);
        exp_t e;
        @(posedge clk);
        #2;
        drive(id, m, d, u, a, b);
        if ((m || d) && (cyc + 1 >= free_e[id])) begin
            e           = model(id == 0 ? 32 : 8, m, u, a, b);
            e.e         = cyc + 1;
            free_e[id]  = e.e + e.lat + 1;
            if (id == 0) q0.push_back(e);
            else         q1.push_back(e);
        end
        @(posedge clk);
        #2;
        drive(id, 0, 0, 1'($urandom), $urandom, $urandom);
    endtask

    task automatic mon(input int id, input logic bz,
                       input logic dn, input logic dz,
                       input logic [31:0] h, input logic [31:0] l);
        exp_t e;
        bit   have;
        int   last;
        e    = '{hi: 0, lo: 0, dbz: 0, wr: 0, e: 0, lat: 0};
        have = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) begin
            if (id == 0) e = q0[0];
            else         e = q1[0];
        end
        last = e.e + e.lat - 1;
        chk($sformatf("busy[%0d]", id), 32'(bz),
            32'(have && cyc >= e.e));
        chk($sformatf("done[%0d]", id), 32'(dn),
            32'(have && cyc == last));
        if (have && cyc >= last) begin
            if (e.wr) begin
                hh[id] = e.hi;
                hl[id] = e.lo;
            end
            hd[id] = e.dbz;
            if (id == 0) void'(q0.pop_front());
            else         void'(q1.pop_front());
        end
        chk($sformatf("hi[%0d]", id), h, hh[id]);
        chk($sformatf("lo[%0d]", id), l, hl[id]);
        chk($sformatf("dbz[%0d]", id), 32'(dz), 32'(hd[id]));
    endtask

    always @(negedge clk) begin
        if (reset) begin
            mon(0, b32.busy, b32.done, b32.div_by_zero,
                b32.hi, b32.lo);
            mon(1, b8.busy, b8.done, b8.div_by_zero,
                32'(b8.hi), 32'(b8.lo));
        end
    end

    task automatic chk_zero();
        chk("rst_busy32", 32'(b32.busy), 0);
        chk("rst_done32", 32'(b32.done), 0);
        chk("rst_dbz32", 32'(b32.div_by_zero), 0);
        chk("rst_hi32", b32.hi, 0);
        chk("rst_lo32", b32.lo, 0);
        chk("rst_busy8", 32'(b8.busy), 0);
        chk("rst_done8", 32'(b8.done), 0);
        chk("rst_dbz8", 32'(b8.div_by_zero), 0);
        chk("rst_hi8", 32'(b8.hi), 0);
        chk("rst_lo8", 32'(b8.lo), 0);
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            free_e[i] = 0;
            hh[i]     = '0;
            hl[i]     = '0;
            hd[i]     = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q0.size() + q1.size()) != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("idle_timeout", 32'(q0.size() + q1.size()), 0);
            q0.delete();
            q1.delete();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            4:       return 32'hFFFF_FF80;
            5:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit          m, d, u;
        int          id, k;
        logic [31:0] a, b;
        model_reset();
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #12;
        chk_zero();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;

        issue(0, 1, 0, 0, 32'd7, 32'hFFFF_FFFD);
        wait_idle();
        issue(0, 1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle();
        issue(0, 0, 1, 0, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        issue(0, 0, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        issue(0, 0, 1, 1, 32'd95, 32'd10);
        wait_idle();
        issue(0, 0, 1, 0, 32'd10, 32'd0);
        wait_idle();
        issue(0, 0, 1, 0, 32'd100, 32'd7);
        wait_idle();

        issue(0, 1, 0, 0, $urandom, $urandom);
        issue(0, 0, 1, 0, $urandom, $urandom);
        issue(0, 1, 0, 1, $urandom, $urandom);
        wait_idle();
        issue(0, 1, 1, 1, 32'h0001_2345, 32'h0000_6789);
        wait_idle();

        issue(1, 0, 1, 1, 32'd200, 32'd7);
        wait_idle();
        issue(1, 0, 1, 0, 32'h80, 32'hFF);
        wait_idle();
        issue(1, 1, 0, 0, 32'h80, 32'h80);
        wait_idle();

        issue(0, 1, 0, 0, $urandom, $urandom);
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk_zero();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        issue(0, 1, 0, 0, 32'd7, 32'hFFFF_FFFD);
        wait_idle();

        for (int i = 0; i < 60; i++) begin
            id = $urandom_range(0, 1);
            k  = $urandom_range(0, 9);
            m  = (k < 4) || (k == 9);
            d  = (k >= 4);
            u  = 1'($urandom);
            a  = pick();
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : pick();
            issue(id, m, d, u, a, b);
            if ($urandom_range(0, 2) == 0) wait_idle();
            else repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        wait_idle();
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nbad);
        $finish;
    end

endmodule
